// File: rtl/reg_writeback.sv
// Write-side register file: routes one microcode nibble per enabled step into A/B/X/Y/SP/temps
// or out to memory, then applies X/Y post-increment and SP push/pop adjustments.
package types_pkg;
    typedef enum logic [4:0] {
        REG_A, REG_B, REG_TEMPA, REG_TEMPB,
        REG_XL, REG_XH, REG_XP, REG_YL, REG_YH, REG_YP,
        REG_SPL, REG_SPH,
        REG_MX, REG_MY, REG_MSP, REG_MSP_INC, REG_Mn,
        REG_ALU, REG_FLAGS, REG_PCL, REG_PCH, REG_PCP,
        REG_IMM_L, REG_IMM_H, REG_ZERO, REG_ONE
    } reg_type;
endpackage

module reg_writeback
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_2x_en,
    input  logic        is_write,
    input  reg_type     selector,
    input  logic [3:0]  in,
    input  logic [7:0]  immed,
    input  logic        inc_x,
    input  logic        inc_y,
    input  logic        sp_inc,
    input  logic        sp_dec,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [3:0]  temp_a,
    output logic [3:0]  temp_b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  sp,
    output logic        mem_write_en,
    output logic [11:0] mem_write_addr,
    output logic [3:0]  mem_write_data
);
    logic [3:0]  a_q, a_d, b_q, b_d, temp_a_q, temp_a_d, temp_b_q, temp_b_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [7:0]  sp_q, sp_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_data_q, mem_data_d;
    logic        unused_immed_hi;

    assign unused_immed_hi = ^immed[7:4];

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        temp_a_d   = temp_a_q;
        temp_b_d   = temp_b_q;
        x_d        = x_q;
        y_d        = y_q;
        sp_d       = sp_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (clk_2x_en) begin
            if (is_write) begin
                // Memory addresses are taken from the _q values, i.e. before this step's adjustments.
                unique case (selector)
                    REG_A:       a_d        = in;
                    REG_B:       b_d        = in;
                    REG_TEMPA:   temp_a_d   = in;
                    REG_TEMPB:   temp_b_d   = in;
                    REG_XL:      x_d[3:0]   = in;
                    REG_XH:      x_d[7:4]   = in;
                    REG_XP:      x_d[11:8]  = in;
                    REG_YL:      y_d[3:0]   = in;
                    REG_YH:      y_d[7:4]   = in;
                    REG_YP:      y_d[11:8]  = in;
                    REG_SPL:     sp_d[3:0]  = in;
                    REG_SPH:     sp_d[7:4]  = in;
                    REG_MX:      begin mem_we_d = 1'b1; mem_addr_d = x_q;                     end
                    REG_MY:      begin mem_we_d = 1'b1; mem_addr_d = y_q;                     end
                    REG_MSP:     begin mem_we_d = 1'b1; mem_addr_d = {4'h0, sp_q};            end
                    REG_MSP_INC: begin mem_we_d = 1'b1; mem_addr_d = {4'h0, sp_q + 8'h01};    end
                    REG_Mn:      begin mem_we_d = 1'b1; mem_addr_d = {8'h00, immed[3:0]};     end
                    default:     ;
                endcase
                if (mem_we_d) mem_data_d = in;
            end

            if (inc_x) x_d[7:0] = x_d[7:0] + 8'h01;
            if (inc_y) y_d[7:0] = y_d[7:0] + 8'h01;

            if (sp_inc && !sp_dec)      sp_d = sp_d + 8'h01;
            else if (sp_dec && !sp_inc) sp_d = sp_d - 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            temp_a_q   <= '0;
            temp_b_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sp_q       <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            temp_a_q   <= temp_a_d;
            temp_b_q   <= temp_b_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sp_q       <= sp_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign temp_a         = temp_a_q;
    assign temp_b         = temp_b_q;
    assign x              = x_q;
    assign y              = y_q;
    assign sp             = sp_q;
    assign mem_write_en   = mem_we_q;
    assign mem_write_addr = mem_addr_q;
    assign mem_write_data = mem_data_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, hand sequences, then random steps vs a model.
module tb_reg_writeback;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        reset, clk_2x_en, is_write, inc_x, inc_y, sp_inc, sp_dec;
    reg_type     selector;
    logic [3:0]  din;
    logic [7:0]  immed;
    logic [3:0]  a, b, temp_a, temp_b;
    logic [11:0] x, y;
    logic [7:0]  sp;
    logic        mem_write_en;
    logic [11:0] mem_write_addr;
    logic [3:0]  mem_write_data;

    int errors = 0;
    int checks = 0;

    // Reference state held as plain integers.
    int m_a, m_b, m_ta, m_tb, m_x, m_y, m_sp, m_we, m_addr, m_data;

    reg_writeback dut (
        .clk(clk), .reset(reset), .clk_2x_en(clk_2x_en), .is_write(is_write),
        .selector(selector), .in(din), .immed(immed), .inc_x(inc_x), .inc_y(inc_y),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .a(a), .b(b), .temp_a(temp_a), .temp_b(temp_b),
        .x(x), .y(y), .sp(sp), .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    function automatic int set_nib(int v, int k, int n);
        return (v & ~(15 << (4 * k))) | (n << (4 * k));
    endfunction

    task automatic model_step(input int en, input int wr, input reg_type sel, input int d,
                              input int imm, input int ix, input int iy, input int si,
                              input int sd, input int rst);
        int px, py, psp;
        if (rst != 0) begin
            m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; m_x = 0; m_y = 0; m_sp = 0;
            m_we = 0; m_addr = 0; m_data = 0;
            return;
        end
        m_we = 0;
        if (en == 0) return;
        px = m_x; py = m_y; psp = m_sp;
        if (wr != 0) begin
            case (sel)
                REG_A:       m_a  = d;
                REG_B:       m_b  = d;
                REG_TEMPA:   m_ta = d;
                REG_TEMPB:   m_tb = d;
                REG_XL:      m_x  = set_nib(m_x, 0, d);
                REG_XH:      m_x  = set_nib(m_x, 1, d);
                REG_XP:      m_x  = set_nib(m_x, 2, d);
                REG_YL:      m_y  = set_nib(m_y, 0, d);
                REG_YH:      m_y  = set_nib(m_y, 1, d);
                REG_YP:      m_y  = set_nib(m_y, 2, d);
                REG_SPL:     m_sp = set_nib(m_sp, 0, d);
                REG_SPH:     m_sp = set_nib(m_sp, 1, d);
                REG_MX:      begin m_we = 1; m_addr = px;                 m_data = d; end
                REG_MY:      begin m_we = 1; m_addr = py;                 m_data = d; end
                REG_MSP:     begin m_we = 1; m_addr = psp;                m_data = d; end
                REG_MSP_INC: begin m_we = 1; m_addr = (psp + 1) % 256;    m_data = d; end
                REG_Mn:      begin m_we = 1; m_addr = imm % 16;           m_data = d; end
                default: ;
            endcase
        end
        if (ix != 0) m_x = (m_x / 256) * 256 + ((m_x % 256) + 1) % 256;
        if (iy != 0) m_y = (m_y / 256) * 256 + ((m_y % 256) + 1) % 256;
        if (si != 0 && sd == 0) m_sp = (m_sp + 1) % 256;
        if (sd != 0 && si == 0) m_sp = (m_sp + 255) % 256;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " a"}, a, m_a);
        check({tag, " b"}, b, m_b);
        check({tag, " temp_a"}, temp_a, m_ta);
        check({tag, " temp_b"}, temp_b, m_tb);
        check({tag, " x"}, x, m_x);
        check({tag, " y"}, y, m_y);
        check({tag, " sp"}, sp, m_sp);
        check({tag, " we"}, mem_write_en, m_we);
        check({tag, " addr"}, mem_write_addr, m_addr);
        check({tag, " data"}, mem_write_data, m_data);
    endtask

    // Drive one cycle's inputs, let the edge happen, update the model, then settle past the edge.
    task automatic do_step(input logic en, input logic wr, input reg_type sel, input logic [3:0] d,
                           input logic [7:0] imm, input logic ix, input logic iy,
                           input logic si, input logic sd, input logic rst);
        reset = rst; clk_2x_en = en; is_write = wr; selector = sel; din = d; immed = imm;
        inc_x = ix; inc_y = iy; sp_inc = si; sp_dec = sd;
        @(posedge clk);
        model_step(int'(en), int'(wr), sel, int'(d), int'(imm), int'(ix), int'(iy),
                   int'(si), int'(sd), int'(rst));
        #1;
    endtask

    typedef struct {
        logic        en;
        logic        wr;
        reg_type     sel;
        logic [3:0]  d;
        logic        ix;
        logic        si;
        logic        sd;
        logic [11:0] ex_x;
        logic [7:0]  ex_sp;
        logic        ex_we;
        logic [11:0] ex_addr;
        logic [3:0]  ex_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b1, REG_XL,      4'hF, 1'b0, 1'b0, 1'b0, 12'h00F, 8'h00, 1'b0, 12'h000, 4'h0};
        vecs[1] = '{1'b1, 1'b1, REG_XH,      4'hF, 1'b0, 1'b0, 1'b0, 12'h0FF, 8'h00, 1'b0, 12'h000, 4'h0};
        vecs[2] = '{1'b1, 1'b1, REG_XP,      4'h3, 1'b0, 1'b0, 1'b0, 12'h3FF, 8'h00, 1'b0, 12'h000, 4'h0};
        vecs[3] = '{1'b1, 1'b0, REG_A,       4'h0, 1'b1, 1'b0, 1'b0, 12'h300, 8'h00, 1'b0, 12'h000, 4'h0};
        vecs[4] = '{1'b1, 1'b0, REG_A,       4'h0, 1'b0, 1'b0, 1'b1, 12'h300, 8'hFF, 1'b0, 12'h000, 4'h0};
        vecs[5] = '{1'b1, 1'b0, REG_A,       4'h0, 1'b0, 1'b1, 1'b1, 12'h300, 8'hFF, 1'b0, 12'h000, 4'h0};
        vecs[6] = '{1'b1, 1'b1, REG_MSP_INC, 4'hA, 1'b0, 1'b0, 1'b0, 12'h300, 8'hFF, 1'b1, 12'h000, 4'hA};
        vecs[7] = '{1'b1, 1'b0, REG_A,       4'h0, 1'b0, 1'b0, 1'b0, 12'h300, 8'hFF, 1'b0, 12'h000, 4'hA};

        do_step(1'b0, 1'b0, REG_A, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_step(1'b1, 1'b1, REG_MX, 4'h7, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("reset x", x, 0);
        check("reset sp", sp, 0);
        check("reset we", mem_write_en, 0);
        check("reset addr", mem_write_addr, 0);
        check("reset a", a, 0);

        for (int i = 0; i < 8; i++) begin
            do_step(vecs[i].en, vecs[i].wr, vecs[i].sel, vecs[i].d, 8'h00, vecs[i].ix, 1'b0,
                    vecs[i].si, vecs[i].sd, 1'b0);
            check($sformatf("vec%0d x", i), x, vecs[i].ex_x);
            check($sformatf("vec%0d sp", i), sp, vecs[i].ex_sp);
            check($sformatf("vec%0d we", i), mem_write_en, vecs[i].ex_we);
            check($sformatf("vec%0d addr", i), mem_write_addr, vecs[i].ex_addr);
            check($sformatf("vec%0d data", i), mem_write_data, vecs[i].ex_data);
        end

        // x = 12'h123, then MX write with inc_x in the same step.
        do_step(1'b1, 1'b1, REG_XL, 4'h3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_step(1'b1, 1'b1, REG_XH, 4'h2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_step(1'b1, 1'b1, REG_XP, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("x setup", x, 'h123);
        do_step(1'b1, 1'b1, REG_MX, 4'h5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mx we", mem_write_en, 1);
        check("mx addr", mem_write_addr, 'h123);
        check("mx data", mem_write_data, 5);
        check("mx x inc", x, 'h124);
        // Strobe must drop even with the step enable low.
        do_step(1'b0, 1'b1, REG_MY, 4'h9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("strobe drop we", mem_write_en, 0);
        check("strobe hold addr", mem_write_addr, 'h123);
        check("disabled y", y, 0);

        do_step(1'b1, 1'b1, REG_ALU, 4'hC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu we", mem_write_en, 0);
        check("alu a", a, 0);
        check("alu x", x, 'h124);
        do_step(1'b0, 1'b1, REG_A, 4'h6, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("en low a", a, 0);
        check("en low x", x, 'h124);
        check("en low sp", sp, 'hFF);
        do_step(1'b1, 1'b1, REG_A, 4'h6, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a write", a, 6);

        // Back-to-back memory writes, including REG_Mn addressing.
        do_step(1'b1, 1'b1, REG_Mn, 4'h2, 8'hE9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mn we", mem_write_en, 1);
        check("mn addr", mem_write_addr, 'h009);
        do_step(1'b1, 1'b1, REG_MSP, 4'h4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("msp we", mem_write_en, 1);
        check("msp addr", mem_write_addr, 'h0FF);
        check("msp sp", sp, 'hFE);

        do_step(1'b1, 1'b1, REG_MY, 4'h8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst we", mem_write_en, 0);
        check_model("rst all");
        check("rst x", x, 0);
        check("rst a", a, 0);
        check("rst data", mem_write_data, 0);

        for (int i = 0; i < 3000; i++) begin
            do_step(1'($urandom_range(0, 3) != 0), 1'($urandom), reg_type'($urandom_range(0, 25)),
                    4'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
